// File: rtl/i2c_target.sv
// i2c_target: I2C target front end that turns bus traffic into register-bank
// accesses. A write transfer is address(W), pointer byte, then data bytes; a
// read transfer is address(R) and returns bytes from the current pointer.
//
// Ports
//   clk_i        system clock, at least 16x the SCL frequency
//   rst_ni       synchronous active-low reset
//   scl_i        bus clock (asynchronous to clk_i)
//   sda_io       bus data, open-drain: driven only 1'b0 or released (z)
//   reg_addr_o   current register pointer
//   reg_wdata_o  write data, meaningful while reg_we_o is high
//   reg_we_o     one-cycle write strobe
//   reg_re_o     one-cycle strobe marking the cycle reg_rdata_i is captured
//   reg_rdata_i  read data for reg_addr_o, combinational in the same cycle
//   busy_o       high while this target is addressed
//   state_o      current FSM state, for debug and checkers
//
// Register-bank handshake: there is no back-pressure. reg_we_o and reg_re_o
// are single-cycle strobes that never overlap; the bank must accept a write
// in the strobe cycle and present reg_rdata_i for reg_addr_o in that same
// cycle when reg_re_o is high.
module i2c_target #(
    parameter logic [6:0] ADDRESS = 7'h40
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    inout  wire        sda_io,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    output logic       reg_re_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_t;

    // [0],[1] synchronizer stages, [2] history flop used for edge detection.
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge clk_i) begin
        scl_q <= {scl_q[1:0], scl_i};
        sda_q <= {sda_q[1:0], sda_io};
    end

    logic scl_s, scl_h, sda_s, sda_h;
    assign scl_s = scl_q[1];
    assign scl_h = scl_q[2];
    assign sda_s = sda_q[1];
    assign sda_h = sda_q[2];

    logic scl_rise, scl_fall, start_ev, stop_ev;
    assign scl_rise = scl_s & ~scl_h;
    assign scl_fall = ~scl_s & scl_h;
    assign start_ev = scl_s & scl_h & sda_h & ~sda_s;
    assign stop_ev  = scl_s & scl_h & ~sda_h & sda_s;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       full, full_n;     // eight bits have been clocked in this byte
    logic [7:0] shift, shift_n;   // receive shifter
    logic [7:0] tx, tx_n;         // transmit shifter, bit 7 is next to drive
    logic       rw, rw_n;
    logic       mack, mack_n;     // master acknowledged the byte just sent
    logic [7:0] ptr, ptr_n;
    logic [7:0] wdata, wdata_n;
    logic       we, we_n, re, re_n;
    logic       busy, busy_n;
    logic       oe, oe_n;         // 1 = pull SDA low

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= S_IDLE;
            bit_cnt <= 3'd0;
            full    <= 1'b0;
            shift   <= 8'd0;
            tx      <= 8'd0;
            rw      <= 1'b0;
            mack    <= 1'b0;
            ptr     <= 8'd0;
            wdata   <= 8'd0;
            we      <= 1'b0;
            re      <= 1'b0;
            busy    <= 1'b0;
            oe      <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            full    <= full_n;
            shift   <= shift_n;
            tx      <= tx_n;
            rw      <= rw_n;
            mack    <= mack_n;
            ptr     <= ptr_n;
            wdata   <= wdata_n;
            we      <= we_n;
            re      <= re_n;
            busy    <= busy_n;
            oe      <= oe_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        full_n    = full;
        shift_n   = shift;
        tx_n      = tx;
        rw_n      = rw;
        mack_n    = mack;
        ptr_n     = ptr;
        wdata_n   = wdata;
        we_n      = 1'b0;
        re_n      = 1'b0;
        busy_n    = busy;
        oe_n      = oe;

        // The write strobe is issued with the old pointer; advance it one
        // cycle later so the bank sees a stable address during the strobe.
        if (we) begin
            ptr_n = ptr + 8'd1;
        end

        if (start_ev) begin
            state_n   = S_ADDR;
            bit_cnt_n = 3'd0;
            full_n    = 1'b0;
            oe_n      = 1'b0;
        end else if (stop_ev) begin
            state_n   = S_IDLE;
            bit_cnt_n = 3'd0;
            full_n    = 1'b0;
            oe_n      = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda_s};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            full_n = 1'b1;
                        end
                    end else if (scl_fall && full) begin
                        full_n = 1'b0;
                        case (state)
                            S_ADDR: begin
                                // General call (0x00) is never acknowledged.
                                if (shift[7:1] == ADDRESS && shift[7:1] != 7'd0) begin
                                    oe_n    = 1'b1;
                                    rw_n    = shift[0];
                                    busy_n  = 1'b1;
                                    state_n = S_ADDR_ACK;
                                end else begin
                                    oe_n    = 1'b0;
                                    busy_n  = 1'b0;
                                    state_n = S_IGNORE;
                                end
                            end
                            S_PTR: begin
                                ptr_n   = shift;
                                oe_n    = 1'b1;
                                state_n = S_PTR_ACK;
                            end
                            default: begin
                                wdata_n = shift;
                                we_n    = 1'b1;
                                oe_n    = 1'b1;
                                state_n = S_WDATA_ACK;
                            end
                        endcase
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_n = 3'd0;
                        full_n    = 1'b0;
                        if (!rw) begin
                            oe_n    = 1'b0;
                            state_n = S_PTR;
                        end else begin
                            tx_n    = {reg_rdata_i[6:0], 1'b0};
                            oe_n    = ~reg_rdata_i[7];
                            re_n    = 1'b1;
                            state_n = S_RDATA;
                        end
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        oe_n      = 1'b0;
                        bit_cnt_n = 3'd0;
                        full_n    = 1'b0;
                        state_n   = S_WDATA;
                    end
                end
                S_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            full_n = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (full) begin
                            oe_n    = 1'b0;
                            full_n  = 1'b0;
                            mack_n  = 1'b0;
                            state_n = S_RDATA_ACK;
                        end else begin
                            oe_n = ~tx[7];
                            tx_n = {tx[6:0], 1'b0};
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            mack_n = 1'b1;
                            ptr_n  = ptr + 8'd1;
                        end else begin
                            busy_n  = 1'b0;
                            state_n = S_IGNORE;
                        end
                    end else if (scl_fall && mack) begin
                        // Pointer already advanced on the ACK rise, so
                        // reg_rdata_i reflects the next register here.
                        mack_n    = 1'b0;
                        bit_cnt_n = 3'd0;
                        full_n    = 1'b0;
                        tx_n      = {reg_rdata_i[6:0], 1'b0};
                        oe_n      = ~reg_rdata_i[7];
                        re_n      = 1'b1;
                        state_n   = S_RDATA;
                    end
                end
                S_IGNORE: begin
                    oe_n   = 1'b0;
                    busy_n = 1'b0;
                end
                default: begin
                    oe_n = 1'b0;
                end
            endcase
        end
    end

    assign sda_io      = oe ? 1'b0 : 1'bz;
    assign reg_addr_o  = ptr;
    assign reg_wdata_o = wdata;
    assign reg_we_o    = we;
    assign reg_re_o    = re;
    assign busy_o      = busy;
    assign state_o     = state;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bus master driven by tasks, a register-bank model,
// and one compare process checking every register strobe against queues of
// expected accesses derived from transaction-level rules.
module tb_i2c_target;
    localparam int Q = 5;  // clk cycles per quarter SCL period (SCL = clk/20)

    logic       clk;
    logic       rst_ni;
    logic       scl;
    logic       m_oe;
    wire        sda_io;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_we_o;
    logic       reg_re_o;
    logic [7:0] reg_rdata_i;
    logic       busy_o;
    logic [3:0] state_o;

    pullup (sda_io);
    assign sda_io = m_oe ? 1'b0 : 1'bz;

    i2c_target #(.ADDRESS(7'h40)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .scl_i       (scl),
        .sda_io      (sda_io),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_rdata_i (reg_rdata_i),
        .busy_o      (busy_o),
        .state_o     (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [7:0]  mem [256];
    logic [7:0]  model_ptr;
    logic [15:0] exp_q[$];     // expected writes {addr, data}
    logic [7:0]  exp_re_q[$];  // expected read-capture addresses
    int          checks;
    int          failures;

    assign reg_rdata_i = mem[reg_addr_o];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_ni && (reg_we_o || reg_re_o)) begin
            check("we_re_exclusive", {31'd0, reg_we_o & reg_re_o}, 32'd0);
            if (reg_we_o) begin
                check("we_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check("we_addr_data", {16'd0, reg_addr_o, reg_wdata_o}, {16'd0, exp_q.pop_front()});
                end
            end
            if (reg_re_o) begin
                check("re_expected", {31'd0, exp_re_q.size() != 0}, 32'd1);
                if (exp_re_q.size() != 0) begin
                    check("re_addr", {24'd0, reg_addr_o}, {24'd0, exp_re_q.pop_front()});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_oe = 1'b0; tick(Q);
        scl  = 1'b1; tick(Q);
        m_oe = 1'b1; tick(Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        m_oe = 1'b1; tick(Q);
        scl  = 1'b1; tick(Q);
        m_oe = 1'b0; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        m_oe = ~b;  tick(Q);
        scl  = 1'b1; tick(2 * Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        m_oe = 1'b0; tick(Q);
        scl  = 1'b1; tick(Q);
        b    = sda_io; tick(Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(a);
        check(name, {31'd0, ~a}, {31'd0, exp_ack});
    endtask

    task automatic read_byte(output logic [7:0] b);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            read_bit(x);
            b[i] = x;
        end
    endtask

    // Complete write transfer of n (1..4) data bytes packed MSB-first in d.
    task automatic write_txn(input logic [6:0] a, input logic [7:0] p, input int n, input logic [31:0] d);
        logic       match;
        logic [7:0] b;
        match = (a == 7'h40);
        bus_start();
        send_byte({a, 1'b0}, match, "addr_ack");
        check("busy_addressed", {31'd0, busy_o}, {31'd0, match});
        if (match) model_ptr = p;
        send_byte(p, match, "ptr_ack");
        for (int i = 0; i < n; i++) begin
            b = d[8 * (n - 1 - i) +: 8];
            if (match) begin
                exp_q.push_back({model_ptr, b});
                model_ptr = model_ptr + 8'd1;
            end
            send_byte(b, match, "data_ack");
        end
        bus_stop();
        tick(4);
        check("busy_after_stop", {31'd0, busy_o}, 32'd0);
        check("we_drained", exp_q.size(), 32'd0);
        check("ptr_model", {24'd0, reg_addr_o}, {24'd0, model_ptr});
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0] r0, r1, r2;

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h5A;
        mem[8'h11] = 8'hC3;
        model_ptr = 8'h00;
        scl = 1'b1; m_oe = 1'b0; rst_ni = 1'b0;

        // Reset state
        tick(4);
        check("rst_we", {31'd0, reg_we_o}, 32'd0);
        check("rst_re", {31'd0, reg_re_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_ptr", {24'd0, reg_addr_o}, 32'd0);
        check("rst_wdata", {24'd0, reg_wdata_o}, 32'd0);
        check("rst_sda", {31'd0, sda_io}, 32'd1);
        check("rst_state", {28'd0, state_o}, 32'd0);
        rst_ni = 1'b1;
        tick(10);

        // Single write
        write_txn(7'h40, 8'h06, 1, 32'h0000_00A5);
        check("write1_ptr_lit", {24'd0, reg_addr_o}, 32'h07);

        // Burst write across pointer wrap
        write_txn(7'h40, 8'hFE, 3, 32'h0011_2233);
        check("burst_ptr_lit", {24'd0, reg_addr_o}, 32'h01);

        // Address mismatch: no ACK anywhere, no strobe, pointer untouched
        write_txn(7'h41, 8'h06, 1, 32'h0000_00A5);
        check("mismatch_ptr_lit", {24'd0, reg_addr_o}, 32'h01);

        // Read with repeated start, ACK then NACK
        bus_start();
        send_byte(8'h80, 1'b1, "rd_waddr_ack");
        send_byte(8'h10, 1'b1, "rd_ptr_ack");
        model_ptr = 8'h10;
        bus_start();
        exp_re_q.push_back(model_ptr);
        send_byte(8'h81, 1'b1, "rd_raddr_ack");
        check("rd_busy", {31'd0, busy_o}, 32'd1);
        read_byte(r0);
        check("rd_byte0", {24'd0, r0}, {24'd0, mem[model_ptr]});
        check("rd_byte0_lit", {24'd0, r0}, 32'h5A);
        model_ptr = model_ptr + 8'd1;
        exp_re_q.push_back(model_ptr);
        write_bit(1'b0);
        read_byte(r1);
        check("rd_byte1", {24'd0, r1}, {24'd0, mem[model_ptr]});
        check("rd_byte1_lit", {24'd0, r1}, 32'hC3);
        write_bit(1'b1);
        m_oe = 1'b0;
        tick(4);
        check("rd_sda_after_nack", {31'd0, sda_io}, 32'd1);
        check("rd_busy_after_nack", {31'd0, busy_o}, 32'd0);
        bus_stop();
        tick(4);
        check("re_drained", exp_re_q.size(), 32'd0);
        check("rd_ptr_lit", {24'd0, reg_addr_o}, 32'h11);

        // Abort after 4 data bits, then a clean write
        bus_start();
        send_byte(8'h80, 1'b1, "ab_addr_ack");
        send_byte(8'h30, 1'b1, "ab_ptr_ack");
        model_ptr = 8'h30;
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        bus_stop();
        tick(4);
        check("ab_state_idle", {28'd0, state_o}, 32'd0);
        check("ab_busy", {31'd0, busy_o}, 32'd0);
        check("ab_ptr_lit", {24'd0, reg_addr_o}, 32'h30);
        write_txn(7'h40, 8'h20, 1, 32'h0000_007E);
        check("ab_clean_ptr_lit", {24'd0, reg_addr_o}, 32'h21);

        // Reset while the target drives a 0 data bit
        bus_start();
        send_byte(8'h80, 1'b1, "rr_waddr_ack");
        send_byte(8'h50, 1'b1, "rr_ptr_ack");
        model_ptr = 8'h50;
        bus_start();
        exp_re_q.push_back(model_ptr);
        send_byte(8'h81, 1'b1, "rr_raddr_ack");
        check("rr_sda_driven", {31'd0, sda_io}, 32'd0);
        rst_ni = 1'b0;
        tick(1);
        rst_ni = 1'b1;
        model_ptr = 8'h00;
        tick(1);
        check("rr_sda_released", {31'd0, sda_io}, 32'd1);
        check("rr_ptr", {24'd0, reg_addr_o}, 32'd0);
        check("rr_busy", {31'd0, busy_o}, 32'd0);
        read_byte(r2);
        check("rr_bus_idle", {24'd0, r2}, 32'hFF);
        bus_stop();
        tick(4);
        check("rr_re_drained", exp_re_q.size(), 32'd0);
        check("rr_ptr_after", {24'd0, reg_addr_o}, {24'd0, model_ptr});

        tick(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) front end that turns bus traffic into register-file accesses for the PWM device.
- Supports write transfers: address, then pointer byte, then data bytes.
- Supports read transfers: address with R/W=1, returning bytes from the current pointer.
- Oversamples SCL/SDA on the system clock and drives SDA open-drain. Sits between the bus pins and the register bank.

Parameters:
- ADDRESS, 7'h40, 7-bit target address this block answers to.

Ports:
- clk_i  input  1  system clock; must be at least 16x SCL frequency.
- rst_ni  input  1  reset, synchronous, active-low.
- scl_i  input  1  bus clock, asynchronous to clk_i.
- sda_io  inout  1  bus data, open-drain. Driven only 1'b0 or 1'bz; read back via the same net.
- reg_addr_o  output  8  current register pointer.
- reg_wdata_o  output  8  write data; valid while reg_we_o=1.
- reg_we_o  output  1  one-cycle write strobe.
- reg_re_o  output  1  one-cycle strobe when reg_rdata_i is captured for transmission.
- reg_rdata_i  input  8  read data for reg_addr_o; combinational, valid in the same cycle.
- busy_o  output  1  high while this target is addressed.

Behaviour:
- Reset (rst_ni=0 at posedge clk_i):
  - state IDLE, SDA released (z), pointer=0.
  - reg_we_o=0, reg_re_o=0, busy_o=0, reg_wdata_o=0.
  - Takes effect even mid-transfer; the block ignores the bus until the next START.
- Input conditioning and event detection:
  - scl_i and sda_io each pass through a 2-flop synchronizer, plus one history flop.
  - All events (edges, START, STOP) are detected 3 clk_i after the pin change.
  - START = SDA falls while SCL high; STOP = SDA rises while SCL high.
  - START/STOP take priority over any data-bit event in the same cycle.
- Bit handling:
  - Data is sampled on the SCL rising edge.
  - The target changes its SDA drive only on the SCL falling edge.
  - Bytes are MSB first; a 3-bit counter marks the 8th bit.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - IDLE: SDA z. START -> ADDR, bit counter cleared.
  - ADDR: shift 8 bits. On the falling edge after the 8th bit:
    - if shift[7:1]==ADDRESS: drive SDA 0, latch rw, busy_o=1, -> ADDR_ACK.
    - otherwise -> IGNORE with SDA z; busy_o stays 0.
  - ADDR_ACK: on the next falling edge:
    - rw=0: release SDA, -> PTR.
    - rw=1: capture reg_rdata_i, pulse reg_re_o, drive SDA from bit 7, -> RDATA.
  - PTR: shift 8 bits. On the falling edge after the 8th bit: load pointer, drive SDA 0, -> PTR_ACK. Next falling edge: release, -> WDATA.
  - WDATA: shift 8 bits. On the falling edge after the 8th bit:
    - reg_wdata_o=byte, reg_we_o=1 for one cycle with reg_addr_o=old pointer.
    - pointer increments in the following cycle (8-bit wrap, FF->00).
    - drive SDA 0, -> WDATA_ACK. Next falling edge: release, -> WDATA.
  - RDATA: shift out 8 bits (SDA z for 1, 0 for 0). On the falling edge after the 8th bit: release SDA, -> RDATA_ACK.
  - RDATA_ACK: sample SDA on the SCL rising edge.
    - 0 (master ACK): pointer+1 (wrap). On the falling edge: capture reg_rdata_i at the new pointer, pulse reg_re_o, -> RDATA.
    - 1 (NACK): pointer unchanged, -> IGNORE.
  - IGNORE: SDA z, busy_o=0. Waits for START/STOP.
- START in any state (repeated start):
  - SDA released, -> ADDR. Pointer retained.
  - busy_o held until address re-evaluation.
- STOP in any state: SDA released, -> IDLE, busy_o=0. A partially received byte is discarded with no strobe.
- General-call address 0x00 is not acknowledged.
- reg_we_o and reg_re_o never assert in the same cycle; each is at most one cycle per byte.

Test Plan:
- Write: addr 0x40 W, ptr 0x06, data 0xA5, STOP -> ACK on all 3 bytes; single reg_we_o with reg_addr_o=0x06, reg_wdata_o=0xA5; pointer=0x07; busy_o low after STOP.
- Burst write: ptr 0xFE, data 0x11,0x22,0x33 -> we at 0xFE/0x11, 0xFF/0x22, 0x00/0x33; final pointer=0x01.
- Address mismatch: addr 0x41 W, 0x06, 0xA5 -> SDA z on every 9th clock; no reg_we_o; busy_o stays 0.
- Read: write ptr 0x10, repeated START, 0x40 R; reg_rdata_i=0x5A@0x10, 0xC3@0x11; master ACK then NACK -> bus bytes 0x5A, 0xC3; two reg_re_o pulses; pointer=0x11; SDA z after NACK.
- Abort: STOP after 4 data bits of a write byte -> no reg_we_o, state IDLE. Then a clean write 0x40/0x20/0x7E -> we at 0x20/0x7E.
- Reset mid-read: rst_ni low for 1 cycle while driving a 0 bit -> SDA z next cycle, pointer=0, no strobes until a new START+matching address.
